// File: rtl/fetch_unit.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake,
// branch/exception redirect and an IF/ID register fronted by a one-entry skid buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_DROP,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic        kill;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign kill     = exc_req | redirect;
    assign target   = exc_req ? EXC_VECTOR : (redirect_pc & ~32'h0000_0003);
    assign pc_plus4 = fetch_pc_q + 32'd4;

    assign imem_req  = !clr && (state_q != ST_HOLD);
    assign imem_addr = fetch_pc_q;
    assign id_inst   = id_inst_q;
    assign id_pc4    = id_pc4_q;
    assign id_valid  = id_valid_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc4_d  = buf_pc4_q;
        id_inst_d  = id_inst_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;

        unique case (state_q)
            ST_REQ: begin
                if (kill) begin
                    id_valid_d = 1'b0;
                    if (imem_ready) begin
                        fetch_pc_d = target;
                    end else begin
                        // request still in flight: keep imem_addr, remember where to go
                        pend_pc_d = target;
                        state_d   = ST_DROP;
                    end
                end else if (imem_ready) begin
                    fetch_pc_d = pc_plus4;
                    if (!stall) begin
                        id_inst_d  = imem_rdata;
                        id_pc4_d   = pc_plus4;
                        id_valid_d = 1'b1;
                    end else begin
                        buf_inst_d = imem_rdata;
                        buf_pc4_d  = pc_plus4;
                        state_d    = ST_HOLD;
                    end
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                end
            end

            ST_DROP: begin
                if (kill) begin
                    pend_pc_d  = target;
                    id_valid_d = 1'b0;
                end
                if (!stall) begin
                    id_valid_d = 1'b0;
                end
                if (imem_ready) begin
                    fetch_pc_d = kill ? target : pend_pc_q;
                    state_d    = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (kill) begin
                    id_valid_d = 1'b0;
                    fetch_pc_d = target;
                    state_d    = ST_REQ;
                end else if (!stall) begin
                    id_inst_d  = buf_inst_q;
                    id_pc4_d   = buf_pc4_q;
                    id_valid_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            buf_inst_q <= '0;
            buf_pc4_q  <= '0;
            id_inst_q  <= '0;
            id_pc4_q   <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc4_q  <= buf_pc4_d;
            id_inst_q  <= id_inst_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a transaction-level model predicts the fetch address
// stream and the instructions that must reach IF/ID; a monitor compares after each edge.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC = 32'h0000_0008;

    logic        clk;
    logic        clr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exc_req;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        id_valid;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .EXC_VECTOR(EXC_PC)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .exc_req    (exc_req),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .id_inst    (id_inst),
        .id_pc4     (id_pc4),
        .id_valid   (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic ok,
                                input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (ok === 1'b1) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Expected {inst, pc4} pairs that must still appear on IF/ID
    logic [63:0] sb_q[$];

    // Reference model state
    logic [31:0] exp_addr = RST_PC;
    logic        poisoned = 1'b0;
    logic        holding  = 1'b0;

    // Memory model
    int unsigned min_wait = 0;
    int unsigned max_wait = 0;
    logic        spurious_en = 1'b0;
    logic        busy = 1'b0;
    int unsigned wait_left = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h1234_5678;
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic cycle(input logic c, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic ex);
        logic        kill;
        logic [31:0] tgt;
        logic        acc;
        @(negedge clk);
        clr         = c;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        exc_req     = ex;
        #1;
        if (c) begin
            busy       = 1'b0;
            imem_ready = 1'b0;
            imem_rdata = $urandom;
        end else if (imem_req) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = $urandom_range(max_wait, min_wait);
            end
            imem_ready = (wait_left == 0);
            if (imem_ready) busy = 1'b0;
            else wait_left--;
            imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
        end else begin
            imem_ready = spurious_en && ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
        end
        #1;
        kill = rd | ex;
        tgt  = ex ? EXC_PC : (rpc & ~32'h3);
        if (c) begin
            chk("req_in_reset", imem_req == 1'b0, {64'd0, imem_req}, 65'd0);
            sb_q.delete();
            exp_addr = RST_PC;
            poisoned = 1'b0;
            holding  = 1'b0;
        end else begin
            chk("imem_req", imem_req == !holding, {64'd0, imem_req}, {64'd0, !holding});
            if (imem_req && !poisoned)
                chk("imem_addr", imem_addr == exp_addr, {33'd0, imem_addr}, {33'd0, exp_addr});
            acc = imem_req & imem_ready;
            if (kill) begin
                sb_q.delete();
                holding  = 1'b0;
                poisoned = imem_req & !imem_ready;
                exp_addr = tgt;
            end else if (acc) begin
                if (poisoned) begin
                    poisoned = 1'b0;
                end else begin
                    sb_q.push_back({mem_word(exp_addr), exp_addr + 32'd4});
                    exp_addr = exp_addr + 32'd4;
                    if (st) holding = 1'b1;
                end
            end else if (holding && !st) begin
                holding = 1'b0;
            end
        end
    endtask

    // Monitor: inputs are stable from the preceding negedge, so they are the sampled values
    logic [64:0] prev_id = '0;
    always @(posedge clk) begin
        logic [63:0] e;
        #1;
        if (clr) begin
            chk("reset_valid", id_valid == 1'b0, {64'd0, id_valid}, 65'd0);
            chk("reset_id", {id_inst, id_pc4} == 64'd0, {1'b0, id_inst, id_pc4}, 65'd0);
        end else if (redirect || exc_req) begin
            chk("kill_bubble", id_valid == 1'b0, {64'd0, id_valid}, 65'd0);
        end else if (stall) begin
            chk("stall_hold", {id_valid, id_inst, id_pc4} == prev_id,
                {id_valid, id_inst, id_pc4}, prev_id);
        end else begin
            chk("deliver_valid", id_valid == (sb_q.size() != 0),
                {64'd0, id_valid}, {64'd0, sb_q.size() != 0});
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (id_valid)
                    chk("deliver_data", {id_inst, id_pc4} == e, {1'b0, id_inst, id_pc4}, {1'b0, e});
            end
        end
        prev_id = {id_valid, id_inst, id_pc4};
    end

    initial begin
        clr = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; exc_req = 1'b0;
        imem_ready = 1'b0; imem_rdata = '0;

        // zero-wait streaming from reset
        min_wait = 0; max_wait = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);

        // stall while the fetch at 0x10 returns, hold 3 cycles, release
        cycle(0, 0, 1, 32'h0000_0010, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);

        // 3-wait memory, redirect to unaligned target in the first wait cycle
        min_wait = 3; max_wait = 3;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0103, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);

        // exception beats a simultaneous redirect
        min_wait = 0; max_wait = 0;
        cycle(0, 0, 1, 32'h0000_0200, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);

        // PC wrap at the top of the address space
        cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);

        // reset while a dropped request is still outstanding
        min_wait = 3; max_wait = 3;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'h0000_0040, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0);

        // randomized traffic
        min_wait = 0; max_wait = 3; spurious_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) == 0,
                  rpc,
                  $urandom_range(0, 31) == 0);
        end

        cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
